// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: motion strobe, start button and paddle positions in,
// ball position, scores and game status out.
interface pong_game_ctrl_if;
    logic       move_tick;
    logic       btn_start;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       ball_visible;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [2:0] state;
    logic [1:0] winner;
    logic       point_strobe;

    // Driver side: supplies strobes, button and paddles, observes the game.
    modport master (
        output move_tick, btn_start, paddle1_y, paddle2_y,
        input  ball_x, ball_y, ball_visible, score1, score2, state, winner, point_strobe
    );

    // Controller side.
    modport slave (
        input  move_tick, btn_start, paddle1_y, paddle2_y,
        output ball_x, ball_y, ball_visible, score1, score2, state, winner, point_strobe
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game controller: serve/play/point/game-over sequencing, ball motion
// with wall bounces and paddle hits, scoring and winner detection.
// Every output comes straight from a register.
module pong_game_ctrl #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned PADDLE_SIZE   = 64,
    parameter int unsigned PADDLE_WIDTH  = 16,
    parameter int unsigned BALL_SIZE     = 8,
    parameter int unsigned WIN_SCORE     = 9,
    parameter int unsigned POINT_TICKS   = 64
) (
    input  logic               clk_25mhz,
    input  logic               clk_locked,
    pong_game_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SERVE    = 3'd1,
        S_PLAY     = 3'd2,
        S_POINT    = 3'd3,
        S_GAMEOVER = 3'd4
    } state_t;

    localparam int unsigned PT_W = (POINT_TICKS > 1) ? $clog2(POINT_TICKS) : 1;

    localparam logic [9:0]  CENTER_X = 10'(SCREEN_WIDTH / 2);
    localparam logic [9:0]  CENTER_Y = 10'(SCREEN_HEIGHT / 2);
    localparam logic [9:0]  Y_TOP    = 10'(BALL_SIZE);
    localparam logic [9:0]  Y_BOT    = 10'(SCREEN_HEIGHT - BALL_SIZE);
    localparam logic [9:0]  X_LHIT   = 10'(PADDLE_WIDTH + BALL_SIZE);
    localparam logic [9:0]  X_RHIT   = 10'(SCREEN_WIDTH - PADDLE_WIDTH - BALL_SIZE);
    localparam logic [9:0]  X_LMISS  = 10'(BALL_SIZE);
    localparam logic [9:0]  X_RMISS  = 10'(SCREEN_WIDTH - BALL_SIZE);
    localparam logic [10:0] BS_EXT   = 11'(BALL_SIZE);
    localparam logic [10:0] PS_EXT   = 11'(PADDLE_SIZE);
    localparam logic [3:0]  WIN_Q    = 4'(WIN_SCORE);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(POINT_TICKS - 1);

    // Direction encoding: dir_x 1 = right, dir_y 1 = down.
    state_t          state_q,   state_d;
    logic [9:0]      ball_x_q,  ball_x_d;
    logic [9:0]      ball_y_q,  ball_y_d;
    logic            dir_x_q,   dir_x_d;
    logic            dir_y_q,   dir_y_d;
    logic [3:0]      score1_q,  score1_d;
    logic [3:0]      score2_q,  score2_d;
    logic [1:0]      winner_q,  winner_d;
    logic            strobe_q,  strobe_d;
    logic            visible_q, visible_d;
    logic [PT_W-1:0] pcnt_q,    pcnt_d;
    logic            btn_prev_q, btn_prev_d;
    logic            armed_q,   armed_d;

    logic            press;
    logic            dir_y_new;
    logic [10:0]     by_ext, p1_ext, p2_ext;
    logic            lhit_y, rhit_y;
    logic [3:0]      score1_inc, score2_inc;

    // A press needs a rising button edge, and the button must have been seen
    // low at least once since reset so a button held through reset is ignored.
    assign press = bus.btn_start & ~btn_prev_q & armed_q;

    // Vertical overlap between the ball and each paddle, in 11 bits so the
    // sums cannot wrap.
    assign by_ext = {1'b0, ball_y_q};
    assign p1_ext = {1'b0, bus.paddle1_y};
    assign p2_ext = {1'b0, bus.paddle2_y};
    assign lhit_y = (by_ext + BS_EXT >= p1_ext) && (by_ext - BS_EXT <= p1_ext + PS_EXT);
    assign rhit_y = (by_ext + BS_EXT >= p2_ext) && (by_ext - BS_EXT <= p2_ext + PS_EXT);

    assign score1_inc = score1_q + 4'd1;
    assign score2_inc = score2_q + 4'd1;

    // State and datapath registers; reset returns everything to the idle picture.
    always_ff @(posedge clk_25mhz or negedge clk_locked) begin
        if (!clk_locked) begin
            state_q    <= S_IDLE;
            ball_x_q   <= CENTER_X;
            ball_y_q   <= CENTER_Y;
            dir_x_q    <= 1'b1;
            dir_y_q    <= 1'b0;
            score1_q   <= 4'd0;
            score2_q   <= 4'd0;
            winner_q   <= 2'd0;
            strobe_q   <= 1'b0;
            visible_q  <= 1'b0;
            pcnt_q     <= '0;
            btn_prev_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ball_x_q   <= ball_x_d;
            ball_y_q   <= ball_y_d;
            dir_x_q    <= dir_x_d;
            dir_y_q    <= dir_y_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            winner_q   <= winner_d;
            strobe_q   <= strobe_d;
            visible_q  <= visible_d;
            pcnt_q     <= pcnt_d;
            btn_prev_q <= btn_prev_d;
            armed_q    <= armed_d;
        end
    end

    // Next-state, ball motion, scoring and the registered-output precompute.
    always_comb begin
        state_d    = state_q;
        ball_x_d   = ball_x_q;
        ball_y_d   = ball_y_q;
        dir_x_d    = dir_x_q;
        dir_y_d    = dir_y_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        winner_d   = winner_q;
        strobe_d   = 1'b0;
        pcnt_d     = pcnt_q;
        btn_prev_d = bus.btn_start;
        armed_d    = armed_q | ~bus.btn_start;
        dir_y_new  = dir_y_q;

        case (state_q)
            S_IDLE: begin
                ball_x_d = CENTER_X;
                ball_y_d = CENTER_Y;
                score1_d = 4'd0;
                score2_d = 4'd0;
                winner_d = 2'd0;
                if (press) begin
                    state_d = S_SERVE;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end
            end

            S_SERVE: begin
                // Serve direction in x was already chosen when entering SERVE.
                ball_x_d = CENTER_X;
                ball_y_d = CENTER_Y;
                dir_y_d  = 1'b0;
                if (press) begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                if (bus.move_tick) begin
                    if (!dir_x_q && ball_x_q == X_LMISS) begin
                        // Left player conceded: ball stays put, next serve goes left.
                        score2_d = score2_inc;
                        strobe_d = 1'b1;
                        dir_x_d  = 1'b0;
                        pcnt_d   = '0;
                        if (score2_inc == WIN_Q) begin
                            state_d  = S_GAMEOVER;
                            winner_d = 2'd2;
                        end else begin
                            state_d  = S_POINT;
                        end
                    end else if (dir_x_q && ball_x_q == X_RMISS) begin
                        score1_d = score1_inc;
                        strobe_d = 1'b1;
                        dir_x_d  = 1'b1;
                        pcnt_d   = '0;
                        if (score1_inc == WIN_Q) begin
                            state_d  = S_GAMEOVER;
                            winner_d = 2'd1;
                        end else begin
                            state_d  = S_POINT;
                        end
                    end else begin
                        if (ball_y_q == Y_TOP) begin
                            dir_y_new = 1'b1;
                        end else if (ball_y_q == Y_BOT) begin
                            dir_y_new = 1'b0;
                        end
                        dir_y_d  = dir_y_new;
                        ball_y_d = dir_y_new ? ball_y_q + 10'd1 : ball_y_q - 10'd1;

                        if (!dir_x_q && ball_x_q == X_LHIT && lhit_y) begin
                            dir_x_d  = 1'b1;
                            ball_x_d = ball_x_q + 10'd1;
                        end else if (dir_x_q && ball_x_q == X_RHIT && rhit_y) begin
                            dir_x_d  = 1'b0;
                            ball_x_d = ball_x_q - 10'd1;
                        end else begin
                            ball_x_d = dir_x_q ? ball_x_q + 10'd1 : ball_x_q - 10'd1;
                        end
                    end
                end
            end

            S_POINT: begin
                if (bus.move_tick) begin
                    if (pcnt_q == PT_LAST) begin
                        state_d  = S_SERVE;
                        pcnt_d   = '0;
                        ball_x_d = CENTER_X;
                        ball_y_d = CENTER_Y;
                        dir_y_d  = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end

            S_GAMEOVER: begin
                if (press) begin
                    state_d  = S_SERVE;
                    score1_d = 4'd0;
                    score2_d = 4'd0;
                    winner_d = 2'd0;
                    dir_x_d  = 1'b1;
                    dir_y_d  = 1'b0;
                    ball_x_d = CENTER_X;
                    ball_y_d = CENTER_Y;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        visible_d = (state_d == S_SERVE) || (state_d == S_PLAY);
    end

    assign bus.ball_x       = ball_x_q;
    assign bus.ball_y       = ball_y_q;
    assign bus.ball_visible = visible_q;
    assign bus.score1       = score1_q;
    assign bus.score2       = score2_q;
    assign bus.state        = state_q;
    assign bus.winner       = winner_q;
    assign bus.point_strobe = strobe_q;

endmodule
